// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: converts EX->MEM load/store controls into a
// req/gnt/rvalid data-memory transaction, aligns/extends load data, stalls
// the pipeline until the access completes, and flags misaligned accesses
// and memory timeouts.
module mem_stage_lsu #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        valid_i,
  input  logic        mem_read_c_i,
  input  logic        mem_write_c_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [3:0]  dm_wstrb_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] mem_read_data_o,
  output logic        stall_c_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  // Wide enough to hold WAIT_TIMEOUT+1, so a saturated count still compares >= limit.
  localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [1:0]      r_lane;

  logic            w_op, w_store, w_f3_legal, w_aligned, w_legal, w_capture, w_timeout;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wstrb;

  function automatic logic [31:0] f_extract(input logic [2:0] f3,
                                            input logic [1:0] lane,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Decode of the incoming EX->MEM slot: legality and store packing.
  always_comb begin
    w_op    = valid_i & (mem_read_c_i | mem_write_c_i);
    w_store = mem_write_c_i & ~mem_read_c_i;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
      3'b100, 3'b101:         w_f3_legal = ~w_store;
      default:                w_f3_legal = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b01:   w_aligned = ~alu_result_i[0];
      2'b10:   w_aligned = (alu_result_i[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    w_legal = w_f3_legal & w_aligned;
    case (funct3_i[1:0])
      2'b00: begin
        w_wdata = {4{rs2_data_i[7:0]}};
        w_wstrb = 4'b0001 << alu_result_i[1:0];
      end
      2'b01: begin
        w_wdata = {2{rs2_data_i[15:0]}};
        w_wstrb = alu_result_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = rs2_data_i;
        w_wstrb = 4'b1111;
      end
    endcase
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    w_timeout = (WAIT_TIMEOUT != 0) && (r_cnt >= CW'(WAIT_TIMEOUT));
  end

  // Next-state and output logic; completion takes priority over timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_capture       = 1'b0;
    dm_req_o        = 1'b0;
    dm_we_o         = 1'b0;
    dm_addr_o       = '0;
    dm_wdata_o      = '0;
    dm_wstrb_o      = '0;
    mem_read_data_o = '0;
    stall_c_o       = 1'b0;
    misalign_o      = 1'b0;
    bus_err_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_op) begin
          if (!w_legal) begin
            misalign_o = 1'b1;
          end else begin
            w_capture  = 1'b1;
            dm_req_o   = 1'b1;
            dm_we_o    = w_store;
            dm_addr_o  = {alu_result_i[31:2], 2'b00};
            dm_wdata_o = w_store ? w_wdata : '0;
            dm_wstrb_o = w_store ? w_wstrb : '0;
            if (dm_gnt_i && w_store) begin
              stall_c_o = 1'b0;
            end else begin
              stall_c_o   = 1'b1;
              w_cnt_nxt   = CW'(1);
              w_state_nxt = dm_gnt_i ? S_WAIT_R : S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (dm_gnt_i || !w_timeout) begin
          dm_req_o   = 1'b1;
          dm_we_o    = r_we;
          dm_addr_o  = r_addr;
          dm_wdata_o = r_wdata;
          dm_wstrb_o = r_wstrb;
        end
        if (dm_gnt_i && r_we) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (dm_gnt_i) begin
          stall_c_o   = 1'b1;
          w_state_nxt = S_WAIT_R;
          w_cnt_nxt   = w_cnt_inc;
        end else if (w_timeout) begin
          bus_err_o   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          stall_c_o = 1'b1;
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT_R: begin
        if (dm_rvalid_i) begin
          mem_read_data_o = f_extract(r_f3, r_lane, dm_rdata_i);
          w_state_nxt     = S_IDLE;
          w_cnt_nxt       = '0;
        end else if (w_timeout) begin
          bus_err_o   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          stall_c_o = 1'b1;
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (ARESET) begin
      dm_req_o        = 1'b0;
      dm_we_o         = 1'b0;
      dm_addr_o       = '0;
      dm_wdata_o      = '0;
      dm_wstrb_o      = '0;
      mem_read_data_o = '0;
      stall_c_o       = 1'b0;
      misalign_o      = 1'b0;
      bus_err_o       = 1'b0;
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Transaction capture at issue, replayed while waiting for grant.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_lane  <= '0;
    end else if (w_capture) begin
      r_addr  <= {alu_result_i[31:2], 2'b00};
      r_wdata <= w_store ? w_wdata : '0;
      r_wstrb <= w_store ? w_wstrb : '0;
      r_we    <= w_store;
      r_f3    <= funct3_i;
      r_lane  <= alu_result_i[1:0];
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (WAIT_TIMEOUT=8 instance).
module tb_mem_stage_lsu;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        valid_i, mem_read_c_i, mem_write_c_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, rs2_data_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic [3:0]  dm_wstrb_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i, mem_read_data_o;
  logic        stall_c_o, misalign_o, bus_err_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_stage_lsu #(.WAIT_TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .valid_i(valid_i),
    .mem_read_c_i(mem_read_c_i), .mem_write_c_i(mem_write_c_i),
    .funct3_i(funct3_i), .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_wstrb_o(dm_wstrb_o), .dm_gnt_i(dm_gnt_i),
    .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .mem_read_data_o(mem_read_data_o), .stall_c_o(stall_c_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic samp();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    valid_i = 0; mem_read_c_i = 0; mem_write_c_i = 0; funct3_i = 3'b010;
    alu_result_i = '0; rs2_data_i = '0; dm_gnt_i = 0; dm_rvalid_i = 0; dm_rdata_i = '0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    valid_i = 1; mem_read_c_i = rd; mem_write_c_i = wr; funct3_i = f3;
    alu_result_i = addr; rs2_data_i = wd;
  endtask

  // Load granted in the issue cycle, rvalid in the following cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_op(1, 0, f3, addr, '0);
    dm_gnt_i = 1;
    samp();
    check({tag, " req"}, {31'b0, dm_req_o}, 32'd1);
    tick();
    idle_inputs();
    dm_rvalid_i = 1; dm_rdata_i = rdata;
    samp();
    check({tag, " data"}, mem_read_data_o, exp);
    check({tag, " stall"}, {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    ARESET = 1;
    // Reset forces outputs low even with an op presented.
    set_op(1, 0, 3'b010, 32'h100, '0);
    dm_gnt_i = 1;
    samp();
    check("rst req", {31'b0, dm_req_o}, 32'd0);
    check("rst stall", {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();
    ARESET = 0;
    tick();

    // LW 0x100, gnt at issue, rvalid two cycles later.
    set_op(1, 0, 3'b010, 32'h100, '0);
    dm_gnt_i = 1;
    samp();
    check("lw req", {31'b0, dm_req_o}, 32'd1);
    check("lw we", {31'b0, dm_we_o}, 32'd0);
    check("lw addr", dm_addr_o, 32'h100);
    check("lw stall c0", {31'b0, stall_c_o}, 32'd1);
    tick();
    idle_inputs();
    samp();
    check("lw req c1", {31'b0, dm_req_o}, 32'd0);
    check("lw stall c1", {31'b0, stall_c_o}, 32'd1);
    check("lw data c1", mem_read_data_o, 32'h0);
    tick();
    dm_rvalid_i = 1; dm_rdata_i = 32'hDEADBEEF;
    samp();
    check("lw stall c2", {31'b0, stall_c_o}, 32'd0);
    check("lw data c2", mem_read_data_o, 32'hDEADBEEF);
    tick();
    dm_rvalid_i = 1; dm_rdata_i = 32'h12345678;
    samp();
    check("lw stray rvalid", mem_read_data_o, 32'h0);
    tick();
    idle_inputs();

    do_load("lb",  3'b000, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF0000, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102, 32'h80FF0000, 32'h000080FF);
    do_load("lh",  3'b001, 32'h102, 32'h80FF0000, 32'hFFFF80FF);
    do_load("lb1", 3'b000, 32'h101, 32'h00007F00, 32'h0000007F);

    // SH 0x202, grant three cycles late; inputs scrambled after issue.
    set_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dm_gnt_i = 1;
      samp();
      check($sformatf("sh req c%0d", i), {31'b0, dm_req_o}, 32'd1);
      check($sformatf("sh we c%0d", i), {31'b0, dm_we_o}, 32'd1);
      check($sformatf("sh addr c%0d", i), dm_addr_o, 32'h200);
      check($sformatf("sh wdata c%0d", i), dm_wdata_o, 32'hABCDABCD);
      check($sformatf("sh wstrb c%0d", i), {28'b0, dm_wstrb_o}, 32'hC);
      check($sformatf("sh stall c%0d", i), {31'b0, stall_c_o}, (i < 3) ? 32'd1 : 32'd0);
      tick();
      idle_inputs();
      rs2_data_i = 32'hFFFFFFFF; alu_result_i = 32'hFFFFFFFF;
    end
    samp();
    check("sh req after", {31'b0, dm_req_o}, 32'd0);
    tick();
    idle_inputs();

    // SW 0x300 zero-wait.
    set_op(0, 1, 3'b010, 32'h300, 32'hCAFEF00D);
    dm_gnt_i = 1;
    samp();
    check("sw req", {31'b0, dm_req_o}, 32'd1);
    check("sw wdata", dm_wdata_o, 32'hCAFEF00D);
    check("sw wstrb", {28'b0, dm_wstrb_o}, 32'hF);
    check("sw stall", {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();
    samp();
    check("sw req after", {31'b0, dm_req_o}, 32'd0);
    check("sw stall after", {31'b0, stall_c_o}, 32'd0);
    tick();

    // SB lane 1.
    set_op(0, 1, 3'b000, 32'h201, 32'h000000AB);
    dm_gnt_i = 1;
    samp();
    check("sb wdata", dm_wdata_o, 32'hABABABAB);
    check("sb wstrb", {28'b0, dm_wstrb_o}, 32'h2);
    tick();
    idle_inputs();

    // Misaligned LW and illegal store width.
    set_op(1, 0, 3'b010, 32'h101, '0);
    dm_gnt_i = 1;
    samp();
    check("mis req", {31'b0, dm_req_o}, 32'd0);
    check("mis pulse", {31'b0, misalign_o}, 32'd1);
    check("mis stall", {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();
    samp();
    check("mis clear", {31'b0, misalign_o}, 32'd0);
    tick();
    set_op(0, 1, 3'b100, 32'h200, 32'h1);
    samp();
    check("sbu illegal", {31'b0, misalign_o}, 32'd1);
    check("sbu req", {31'b0, dm_req_o}, 32'd0);
    tick();
    idle_inputs();

    // Timeout: no grant ever.
    set_op(1, 0, 3'b010, 32'h400, '0);
    for (int c = 0; c <= 9; c++) begin
      samp();
      if (c < 8) begin
        check($sformatf("to stall c%0d", c), {31'b0, stall_c_o}, 32'd1);
        check($sformatf("to berr c%0d", c), {31'b0, bus_err_o}, 32'd0);
      end else if (c == 8) begin
        check("to berr c8", {31'b0, bus_err_o}, 32'd1);
        check("to req c8", {31'b0, dm_req_o}, 32'd0);
        check("to stall c8", {31'b0, stall_c_o}, 32'd0);
      end else begin
        check("to berr c9", {31'b0, bus_err_o}, 32'd0);
        check("to stall c9", {31'b0, stall_c_o}, 32'd0);
      end
      tick();
      idle_inputs();
    end

    // Reset pulse in WAIT_R, then a stray rvalid.
    set_op(1, 0, 3'b010, 32'h500, '0);
    dm_gnt_i = 1;
    tick();
    idle_inputs();
    samp();
    check("rstmid stall", {31'b0, stall_c_o}, 32'd1);
    tick();
    ARESET = 1;
    samp();
    check("rstmid forced", {31'b0, stall_c_o}, 32'd0);
    tick();
    ARESET = 0;
    dm_rvalid_i = 1; dm_rdata_i = 32'hDEADBEEF;
    samp();
    check("rstmid data", mem_read_data_o, 32'h0);
    check("rstmid stall2", {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();
    // Back in IDLE: a zero-wait store completes without stalling.
    set_op(0, 1, 3'b010, 32'h600, 32'h5);
    dm_gnt_i = 1;
    samp();
    check("rstmid idle req", {31'b0, dm_req_o}, 32'd1);
    check("rstmid idle stall", {31'b0, stall_c_o}, 32'd0);
    tick();
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
